// File: rtl/seg7_595_scan_drv.sv
// seg7_595_scan_drv: double-buffered multiplexed 7-segment scanner driving chained 74HC595 shift registers
module seg7_595_scan_drv #(
  parameter int NUM_DIGITS     = 8,
  parameter int CLK_DIV        = 4,
  parameter int REFRESH_CNT    = 40000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    RSTn,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] hex_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic                    seg7_SH_CP,
  output logic                    seg7_ST_CP,
  output logic                    seg7_DS,
  output logic                    busy,
  output logic                    frame_done
);
  localparam int W  = 8 + NUM_DIGITS;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(W);
  localparam int CW = $clog2(REFRESH_CNT);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SHIFT_L = 3'd1;
  localparam logic [2:0] SHIFT_H = 3'd2;
  localparam logic [2:0] LATCH   = 3'd3;
  localparam logic [2:0] WAIT    = 3'd4;

  logic [2:0]              state;
  logic [DW-1:0]           div_cnt;
  logic [BW-1:0]           bit_cnt;
  logic [CW-1:0]           slot_cnt;
  logic [IW-1:0]           idx;
  logic [W-1:0]            word;
  logic                    blanking;
  logic [4*NUM_DIGITS-1:0] pend_hex, act_hex, use_hex;
  logic [NUM_DIGITS-1:0]   pend_dp, act_dp, use_dp;
  logic [NUM_DIGITS-1:0]   pend_blank, act_blank, use_blank;
  logic [NUM_DIGITS-1:0]   sel;
  logic [IW-1:0]           nxt_idx;
  logic                    first;
  logic [3:0]              nib;
  logic [6:0]              glyph;
  logic [7:0]              seg;
  logic [W-1:0]            digit_word, blank_word;
  logic                    div_end, last_bit, start_digit, start_blank;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // Build the next digit word; the digit-0 build takes pending data, or the inputs directly when loaded that cycle
  always_comb begin
    nxt_idx     = (state == IDLE || idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
    first       = nxt_idx == '0;
    use_hex     = first ? (load ? hex_in : pend_hex) : act_hex;
    use_dp      = first ? (load ? dp_in : pend_dp) : act_dp;
    use_blank   = first ? (load ? blank_in : pend_blank) : act_blank;
    nib         = 4'(use_hex >> {nxt_idx, 2'b00});
    glyph       = hex7(nib);
    seg         = (use_blank[nxt_idx] ? 8'h00 : {use_dp[nxt_idx], glyph}) ^ {8{SEG_ACTIVE_LOW}};
    sel         = (NUM_DIGITS'(1) << nxt_idx) ^ {NUM_DIGITS{SEL_ACTIVE_LOW}};
    digit_word  = {seg, sel};
    blank_word  = {{8{SEG_ACTIVE_LOW}}, {NUM_DIGITS{SEL_ACTIVE_LOW}}};
    div_end     = div_cnt == DW'(CLK_DIV - 1);
    last_bit    = bit_cnt == BW'(W - 1);
    start_digit = enable && (state == IDLE || (state == WAIT && slot_cnt == CW'(REFRESH_CNT - 1)));
    start_blank = !enable && state == WAIT;
  end

  // Pin outputs decode straight from the state so an async reset clears them at once
  always_comb begin
    seg7_SH_CP = state == SHIFT_H;
    seg7_ST_CP = state == LATCH;
    seg7_DS    = (state == SHIFT_L || state == SHIFT_H) && word[W-1];
    busy       = state == SHIFT_L || state == SHIFT_H || state == LATCH;
  end

  // Scan sequencer: shift word MSB first, latch, then wait out the slot; blank word on disable
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      slot_cnt   <= '0;
      idx        <= '0;
      word       <= '0;
      blanking   <= 1'b0;
      frame_done <= 1'b0;
      pend_hex   <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      act_hex    <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
    end else begin
      frame_done <= 1'b0;
      slot_cnt   <= state == IDLE ? '0 : slot_cnt + CW'(1);
      div_cnt    <= (div_end || state == IDLE || state == WAIT) ? '0 : div_cnt + DW'(1);
      if (load) begin
        pend_hex   <= hex_in;
        pend_dp    <= dp_in;
        pend_blank <= blank_in;
      end
      if (start_digit || start_blank) begin
        state    <= SHIFT_L;
        word     <= start_blank ? blank_word : digit_word;
        bit_cnt  <= '0;
        slot_cnt <= '0;
        blanking <= start_blank;
      end
      if (start_digit) idx <= nxt_idx;
      if (start_digit && first) begin
        act_hex   <= use_hex;
        act_dp    <= use_dp;
        act_blank <= use_blank;
      end
      if (div_end && state == SHIFT_L) state <= SHIFT_H;
      if (div_end && state == SHIFT_H) begin
        state   <= last_bit ? LATCH : SHIFT_L;
        word    <= word << 1;
        bit_cnt <= bit_cnt + BW'(1);
      end
      if (div_end && state == LATCH) begin
        state      <= blanking ? IDLE : WAIT;
        frame_done <= !blanking && idx == IW'(NUM_DIGITS - 1);
        blanking   <= 1'b0;
        if (blanking) idx <= '0;
      end
    end
  end
endmodule

// File: tb/tb_seg7_595_scan_drv.sv
// tb_seg7_595_scan_drv: directed table-driven check of the 595 scan driver through a modelled shift/latch chain
module tb_seg7_595_scan_drv;
  localparam int ND = 4;
  localparam int CD = 2;
  localparam int RC = 64;

  logic        clk = 1'b0;
  logic        RSTn, enable, load;
  logic [15:0] hex_in;
  logic [3:0]  dp_in, blank_in;
  logic        sh, st, ds, busy, frame_done;

  seg7_595_scan_drv #(
    .NUM_DIGITS(ND), .CLK_DIV(CD), .REFRESH_CNT(RC), .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .RSTn(RSTn), .enable(enable), .load(load), .hex_in(hex_in), .dp_in(dp_in),
    .blank_in(blank_in), .seg7_SH_CP(sh), .seg7_ST_CP(st), .seg7_DS(ds), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     hex;
    logic [3:0]      dp;
    logic [3:0]      blank;
    logic [3:0][7:0] seg;
  } vec_t;

  vec_t vecs [6];
  int n_vec = 0;
  int n_bad = 0;

  // 74HC595 chain model plus timing bookkeeping, sampled on the falling edge
  logic [11:0] sr = '0;
  logic        psh = 1'b0, pst = 1'b0, pbusy = 1'b0, pds = 1'b0, ds_rise = 1'b0;
  logic [11:0] words [$];
  int          starts [$], fds [$], bfalls [$], blens [$], shn [$], stn [$];
  int          cyc = 0, bstart = 0, sh_cnt = 0, st_cnt = 0, ds_bad = 0;

  always @(negedge clk) begin
    cyc++;
    if (sh && !psh) begin
      sr = {sr[10:0], ds};
      ds_rise = ds;
      if (ds != pds) ds_bad++;
    end
    if (sh && psh && ds != ds_rise) ds_bad++;
    if (st && !pst) words.push_back(sr);
    if (busy && !pbusy) begin
      starts.push_back(cyc);
      bstart = cyc;
      sh_cnt = 0;
      st_cnt = 0;
    end
    if (sh) sh_cnt++;
    if (st) st_cnt++;
    if (!busy && pbusy) begin
      bfalls.push_back(cyc);
      blens.push_back(cyc - bstart);
      shn.push_back(sh_cnt);
      stn.push_back(st_cnt);
    end
    if (frame_done) fds.push_back(cyc);
    psh = sh;
    pst = st;
    pbusy = busy;
    pds = ds;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int k);
    return k == 0 ? words.size() : k == 1 ? starts.size() : k == 2 ? fds.size() : bfalls.size();
  endfunction

  task automatic wait_for(input int k, input int n);
    int t = 0;
    while (qsize(k) < n && t < 3000) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (qsize(k) < n) chk($sformatf("timeout_q%0d", k), qsize(k), n);
  endtask

  function automatic logic [4:0] outs();
    return {sh, st, ds, busy, frame_done};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, w;
    vecs[0] = '{16'h1234, 4'b0001, 4'b0000, {8'hF9, 8'hA4, 8'hB0, 8'h19}};
    vecs[1] = '{16'hFFFF, 4'b0000, 4'b0000, {8'h8E, 8'h8E, 8'h8E, 8'h8E}};
    vecs[2] = '{16'h1234, 4'b0000, 4'b0100, {8'hF9, 8'hFF, 8'hB0, 8'h99}};
    vecs[3] = '{16'hABCD, 4'b1010, 4'b0000, {8'h08, 8'h83, 8'h46, 8'hA1}};
    vecs[4] = '{16'h8905, 4'b0000, 4'b1000, {8'hFF, 8'h90, 8'hC0, 8'h92}};
    vecs[5] = '{16'h67E0, 4'b1111, 4'b0001, {8'h02, 8'h78, 8'h06, 8'hFF}};
    RSTn = 1'b0; enable = 1'b0; load = 1'b0; hex_in = '0; dp_in = '0; blank_in = '0;
    repeat (3) @(negedge clk);
    #1 chk("reset_outputs", 32'(outs()), 32'h0);
    @(negedge clk);
    RSTn = 1'b1;
    @(negedge clk);
    hex_in = 16'h1234; dp_in = 4'b0001; load = 1'b1; enable = 1'b1;
    @(negedge clk);
    load = 1'b0;
    #1 chk("start_next_cycle", 32'(busy), 32'h1);
    wait_for(3, 1);
    chk("first_word", 32'(words[0]), 32'h191);
    chk("first_sh_high_cycles", shn[0], 24);
    chk("first_st_high_cycles", stn[0], 2);
    chk("first_busy_cycles", blens[0], 50);
    wait_for(0, 5);
    chk("word1", 32'(words[1]), 32'hB02);
    chk("word2", 32'(words[2]), 32'hA44);
    chk("word3", 32'(words[3]), 32'hF98);
    chk("word4_wrap", 32'(words[4]), 32'h191);
    for (int i = 0; i < 4; i++) chk($sformatf("slot_gap%0d", i), starts[i+1] - starts[i], RC);
    chk("fd_count_frame1", fds.size(), 1);
    chk("fd_after_last_latch", fds[0], bfalls[3]);
    wait_for(0, 9);
    wait_for(2, 2);
    chk("fd_period", fds[1] - fds[0], 4 * RC);
    wait_for(1, 10);
    hex_in = 16'hFFFF; dp_in = 4'b0000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_for(0, 13);
    chk("midframe_d1_kept", 32'(words[9]), 32'hB02);
    chk("midframe_d2_kept", 32'(words[10]), 32'hA44);
    chk("midframe_d3_kept", 32'(words[11]), 32'hF98);
    chk("midframe_d0_new", 32'(words[12]), 32'h8E1);
    for (int v = 0; v < 6; v++) begin
      wait_for(2, fds.size() + 1);
      hex_in = vecs[v].hex; dp_in = vecs[v].dp; blank_in = vecs[v].blank; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      base = words.size();
      wait_for(0, base + 4);
      for (int i = 0; i < 4; i++)
        chk($sformatf("vec%0d_digit%0d", v, i), 32'(words[base+i]), 32'({vecs[v].seg[i], 4'(1 << i)}));
    end
    w = words.size();
    wait_for(1, starts.size() + 1);
    repeat (21) @(negedge clk);
    enable = 1'b0;
    wait_for(0, w + 2);
    chk("disable_word_completes", 32'(words[w]), 32'hFF1);
    chk("disable_blank_word", 32'(words[w+1]), 32'hFF0);
    repeat (150) @(negedge clk);
    #1 chk("idle_no_more_words", words.size(), w + 2);
    chk("idle_outputs", 32'(outs()), 32'h0);
    enable = 1'b1;
    @(negedge clk);
    #1 chk("restart_next_cycle", 32'(busy), 32'h1);
    repeat (10) @(negedge clk);
    w = words.size();
    #2 RSTn = 1'b0;
    #1 chk("reset_midshift_outputs", 32'(outs()), 32'h0);
    repeat (3) @(negedge clk);
    #1 chk("reset_held_outputs", 32'(outs()), 32'h0);
    chk("reset_no_latch", words.size(), w);
    RSTn = 1'b1;
    wait_for(0, w + 1);
    chk("after_reset_digit0_zero", 32'(words[w]), 32'hC01);
    chk("ds_stable_on_sh_edges", ds_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
